shift_add_multiplier: RTL and testbench

Parametrised sequential multiplier replacing the fixed 16-bit repeated-addition datapath/controller pair. Operands load in parallel on a start handshake. The product is formed by radix-2 shift-and-add, with early termination once the remaining multiplier bits are zero. A per-operation mode selects unsigned or two's-complement signed operands. The block sits as a standalone arithmetic unit driven by a simple start/done controller.

---
 rtl/shift_add_multiplier.sv | 150 +++++++++++++++
 tb/tb_shift_add_multiplier.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
// Sequential radix-2 shift-and-add multiplier with unsigned/signed operand
// modes. Operands are converted to sign and magnitude at load, the magnitudes
// are multiplied, and the sign is applied in a final fix-up cycle. Iteration
// stops as soon as the remaining multiplier bits are all zero, so latency
// tracks the bit length of the multiplier magnitude.
module shift_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of an operand: two's-complement negation when the operand is
    // signed and negative, the raw bits otherwise. The most negative value
    // maps to 2^(WIDTH-1), which still fits the unsigned WIDTH-bit result.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic [WIDTH-1:0] x,
        input logic             is_signed
    );
        logic [WIDTH-1:0] mag;
        if (is_signed && x[WIDTH-1]) begin
            mag = ~x + WIDTH'(1);
        end else begin
            mag = x;
        end
        return mag;
    endfunction

    // Conditional two's-complement negation over the full product width.
    function automatic logic [PW-1:0] apply_sign(
        input logic [PW-1:0] x,
        input logic          negate
    );
        logic [PW-1:0] res;
        if (negate) begin
            res = ~x + PW'(1);
        end else begin
            res = x;
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     product_q, product_d;

    // Next-state and datapath: load on accepted start, iterate while
    // multiplier bits remain, then apply the sign and publish the product.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        // busy is visible from the first CALC cycle onward and drops in the
        // cycle that done rises.
        busy_d    = (state_q == CALC);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                    mplier_d = magnitude(b, signed_mode);
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = {PW{1'b0}};
                    state_d  = CALC;
                end else begin
                    state_d  = IDLE;
                end
            end

            CALC: begin
                if (|mplier_q) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = {mcand_q[PW-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    state_d  = CALC;
                end else begin
                    state_d  = FIX;
                end
            end

            FIX: begin
                product_d = apply_sign(acc_q, neg_q);
                done_d    = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset; reset
    // aborts any operation in flight and clears the published product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= {PW{1'b0}};
            mcand_q   <= {PW{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= {PW{1'b0}};
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: three instances (WIDTH 16, 8, 4) share one
// clock. A behavioural model computes expected product and latency from plain
// signed/unsigned arithmetic and is compared every cycle; lane 0 carries the
// directed vectors, lanes 1 and 2 carry the random / exhaustive sweeps.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st    [3];
    logic        sm    [3];
    logic [15:0] in_a  [3];
    logic [15:0] in_b  [3];
    logic        busy_o[3];
    logic        done_o[3];
    logic [31:0] prod0;
    logic [15:0] prod1;
    logic [7:0]  prod2;
    logic [31:0] dut_prod[3];

    int lw[3] = '{16, 8, 4};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state per lane
    logic        m_act [3];
    int          m_k   [3];
    int          m_lat [3];
    logic [31:0] m_res [3];
    logic [31:0] e_prod[3];
    logic        e_done[3];
    logic        e_busy[3];

    int sw1 = 0;
    int sw2 = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sm[0]),
        .a(in_a[0]), .b(in_b[0]), .busy(busy_o[0]), .done(done_o[0]),
        .product(prod0)
    );

    shift_add_multiplier #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sm[1]),
        .a(in_a[1][7:0]), .b(in_b[1][7:0]), .busy(busy_o[1]), .done(done_o[1]),
        .product(prod1)
    );

    shift_add_multiplier #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(sm[2]),
        .a(in_a[2][3:0]), .b(in_b[2][3:0]), .busy(busy_o[2]), .done(done_o[2]),
        .product(prod2)
    );

    assign dut_prod[0] = prod0;
    assign dut_prod[1] = {16'd0, prod1};
    assign dut_prod[2] = {24'd0, prod2};

    // Operand value as a mathematical integer for a w-bit field.
    function automatic longint sval(int w, logic [15:0] x, logic s);
        longint v;
        v = longint'(x) & ((longint'(1) << w) - 1);
        if (s && v[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic logic [31:0] ref_mul(int w, logic [15:0] x, logic [15:0] y, logic s);
        longint p;
        p = sval(w, x, s) * sval(w, y, s);
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    function automatic int ref_lat(int w, logic [15:0] y, logic s);
        longint m;
        int n;
        m = sval(w, y, s);
        if (m < 0) m = -m;
        n = 0;
        while (m != 0) begin
            n++;
            m = m >> 1;
        end
        return n + 2;
    endfunction

    task automatic chk(string name, int lane, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lane%0d cyc=%0d got=%h exp=%h", name, lane, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        for (int l = 0; l < 3; l++) begin
            if (!rst_n) begin
                m_act[l]  = 1'b0;
                m_k[l]    = 0;
                e_prod[l] = 32'd0;
                e_done[l] = 1'b0;
                e_busy[l] = 1'b0;
            end else begin
                e_done[l] = 1'b0;
                if (m_act[l]) begin
                    m_k[l]++;
                    if (m_k[l] == m_lat[l]) begin
                        e_done[l] = 1'b1;
                        e_prod[l] = m_res[l];
                        m_act[l]  = 1'b0;
                    end
                end else if (st[l]) begin
                    m_act[l] = 1'b1;
                    m_k[l]   = 0;
                    m_res[l] = ref_mul(lw[l], in_a[l], in_b[l], sm[l]);
                    m_lat[l] = ref_lat(lw[l], in_b[l], sm[l]);
                end
                e_busy[l] = m_act[l] && (m_k[l] >= 1);
            end
        end
    endtask

    task automatic drive_sweeps();
        logic [8:0] idx;
        if (!m_act[1] && sw1 < 600) begin
            st[1]   = 1'b1;
            sm[1]   = 1'($urandom_range(0, 1));
            in_a[1] = 16'($urandom_range(0, 255));
            in_b[1] = 16'($urandom_range(0, 255));
            sw1++;
        end else begin
            st[1] = 1'b0;
        end
        if (!m_act[2] && sw2 < 512) begin
            idx     = 9'(sw2);
            st[2]   = 1'b1;
            in_a[2] = {12'd0, idx[3:0]};
            in_b[2] = {12'd0, idx[7:4]};
            sm[2]   = idx[8];
            sw2++;
        end else begin
            st[2] = 1'b0;
        end
    endtask

    // One clock: model update on the rising edge, compare and sweep drive
    // on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            chk("done", l, {31'd0, done_o[l]}, {31'd0, e_done[l]});
            chk("busy", l, {31'd0, busy_o[l]}, {31'd0, e_busy[l]});
            chk("product", l, dut_prod[l], e_prod[l]);
        end
        drive_sweeps();
    endtask

    task automatic run_op(logic [15:0] av, logic [15:0] bv, logic s,
                          logic [31:0] exp_p, int exp_lat);
        int lat;
        int bcnt;
        logic seen;
        in_a[0] = av;
        in_b[0] = bv;
        sm[0]   = s;
        st[0]   = 1'b1;
        tick();
        st[0]   = 1'b0;
        in_a[0] = 16'hDEAD;
        in_b[0] = 16'hBEEF;
        lat  = 0;
        bcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            lat++;
            if (busy_o[0]) bcnt++;
            if (done_o[0]) seen = 1'b1;
        end
        chk("done_seen", 0, {31'd0, seen}, 32'd1);
        chk("lit_product", 0, prod0, exp_p);
        chk("lit_latency", 0, 32'(lat), 32'(exp_lat));
        chk("lit_busy_cycles", 0, 32'(bcnt), 32'(exp_lat - 1));
    endtask

    initial begin
        int guard;
        logic [15:0] tbl [4];
        tbl = '{16'h0003, 16'h0000, 16'h00FF, 16'h8001};
        rst_n = 1'b0;
        for (int l = 0; l < 3; l++) begin
            st[l] = 1'b0; sm[l] = 1'b0; in_a[l] = 16'd0; in_b[l] = 16'd0;
            m_act[l] = 1'b0; m_k[l] = 0; m_lat[l] = 0; m_res[l] = 32'd0;
            e_prod[l] = 32'd0; e_done[l] = 1'b0; e_busy[l] = 1'b0;
        end
        tick();
        tick();
        chk("rst_busy", 0, {31'd0, busy_o[0]}, 32'd0);
        chk("rst_done", 0, {31'd0, done_o[0]}, 32'd0);
        chk("rst_product", 0, prod0, 32'd0);
        chk("model_pin_neg", 0, ref_mul(16, 16'hFFFD, 16'd7, 1'b1), 32'hFFFFFFEB);
        chk("model_pin_lat", 0, 32'(ref_lat(16, 16'h8000, 1'b1)), 32'd18);
        rst_n = 1'b1;
        tick();

        run_op(16'd17,   16'd5,    1'b0, 32'd85,        5);
        run_op(16'd1234, 16'd0,    1'b0, 32'd0,         2);
        run_op(16'd0,    16'hFFFF, 1'b0, 32'd0,         18);
        run_op(16'hFFFD, 16'd7,    1'b1, 32'hFFFFFFEB,  5);
        run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000,  18);
        run_op(16'd7,    16'hFFFF, 1'b1, 32'hFFFFFFF9,  3);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001,  18);

        // start held high with operands changing every cycle
        st[0] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            in_a[0] = 16'(i * 37 + 5);
            in_b[0] = tbl[i % 4] ^ 16'(i);
            sm[0]   = 1'(i % 3 == 0);
            tick();
        end
        st[0] = 1'b0;
        repeat (20) tick();

        // reset pulse in the middle of CALC
        in_a[0] = 16'd9;
        in_b[0] = 16'hFFFF;
        sm[0]   = 1'b0;
        st[0]   = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 0, {31'd0, busy_o[0]}, 32'd0);
        chk("abort_done", 0, {31'd0, done_o[0]}, 32'd0);
        chk("abort_product", 0, prod0, 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        run_op(16'd300, 16'd300, 1'b0, 32'd90000, 11);

        guard = 0;
        while ((sw1 < 600 || sw2 < 512 || m_act[1] || m_act[2]) && guard < 20000) begin
            tick();
            guard++;
        end
        chk("sweep_timeout", 0, 32'(guard < 20000), 32'd1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
